// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and constants for the serial pattern path
//
// Purpose : FSM state enum, default widths and the reference 1011 pattern used
//           by the transmitter and by detector-side logic.
// Ports   : none (package)

package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 4;

    localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter with inter-pattern zero gaps
//
// Purpose : sends a captured PAT_W-bit pattern MSB-first, reps times, with gap
//           zero bits between repetitions and none after the last one.
// Ports   : clk, rst (sync, active-high)
//           start, pattern[PAT_W], reps[CNT_W], gap[GAP_W]  - request, captured in IDLE
//           ser_out, ser_valid                              - serial line and its qualifier
//           pat_end                                         - last bit of each repetition
//           busy                                            - transfer on the line
//           done                                            - one-cycle end-of-transfer pulse
// All outputs come straight from flops; they show the FSM's decision one
// edge after the state that made it.

module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             pat_end,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0]    BIT_LAST = BW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic ser_out_q, ser_out_d;
    logic ser_valid_q, ser_valid_d;
    logic pat_end_q, pat_end_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        pat_end_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        pat_d     = pattern;
                        shift_d   = pattern;
                        rep_cnt_d = reps;
                        gap_len_d = gap;
                        bit_cnt_d = BIT_LAST;
                        state_d   = SEND;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            SEND: begin
                ser_out_d   = shift_q[PAT_W-1];
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
                shift_d     = shift_q << 1;
                bit_cnt_d   = bit_cnt_q - 1'b1;
                if (bit_cnt_q == '0) begin
                    pat_end_d = 1'b1;
                    rep_cnt_d = rep_cnt_q - 1'b1;
                    if (rep_cnt_q == REP_ONE) begin
                        state_d = DONE;
                    end else if (gap_len_q == '0) begin
                        // back-to-back: next repetition starts on the very next bit
                        shift_d   = pat_q;
                        bit_cnt_d = BIT_LAST;
                    end else begin
                        gap_cnt_d = gap_len_q;
                        state_d   = GAP;
                    end
                end
            end

            GAP: begin
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
                gap_cnt_d   = gap_cnt_q - 1'b1;
                if (gap_cnt_q == GAP_ONE) begin
                    shift_d   = pat_q;
                    bit_cnt_d = BIT_LAST;
                    state_d   = SEND;
                end
            end

            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            pat_end_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            pat_end_q   <= pat_end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign pat_end   = pat_end_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard bench for seq_pattern_tx with 1011 detector loopback

module tb_seq_pattern_tx;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern = '0;
    logic [7:0] reps = '0;
    logic [3:0] gap = '0;
    logic       ser_out, ser_valid, pat_end, busy, done;

    seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .reps      (reps),
        .gap       (gap),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .pat_end   (pat_end),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic b;
        logic pe;
        logic det;
    } exp_t;

    exp_t line_q[$];
    int   done_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_valid = 0;
    int   n_pend = 0;
    logic [3:0] det_sh = '0;
    logic       det_hit;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the line carries a bit or done pulses.
    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (ser_valid) begin
            det_hit = ({det_sh[2:0], ser_out} == PAT_1011);
            det_sh  = {det_sh[2:0], ser_out};
            n_valid++;
            if (pat_end) n_pend++;
            if (line_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_line_bit: got ser_valid=1 expected none (edge %0d)", cyc);
            end else begin
                e = line_q.pop_front();
                chk("line_edge", cyc, e.c);
                chk("ser_out", ser_out, e.b);
                chk("pat_end", pat_end, e.pe);
                chk("detector", det_hit, e.det);
                chk("busy_on_line", busy, 1);
            end
        end else begin
            det_sh = '0;
            chk("ser_out_idle", ser_out, 0);
            chk("pat_end_idle", pat_end, 0);
            chk("busy_idle", busy, 0);
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none (edge %0d)", cyc);
            end else begin
                dc = done_q.pop_front();
                chk("done_edge", cyc, dc);
            end
        end
    end

    // One transfer. glitch_at/rst_at are edge offsets from the accepting edge k
    // at which a stray start or a reset is sampled (0 = none).
    task automatic run(input logic [3:0] p, input int r, input int g,
                       input int glitch_at, input int rst_at);
        int k, c, total, ncyc, bv, bp;
        exp_t e;
        @(negedge clk);
        pattern = p;
        reps    = 8'(r);
        gap     = 4'(g);
        start   = 1'b1;
        k       = cyc + 1;
        bv      = n_valid;
        bp      = n_pend;
        total   = (r > 0) ? r * 4 + (r - 1) * g : 0;

        c = k + 1;
        for (int i = 0; i < r; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (rst_at == 0 || c < k + rst_at) begin
                    e.c   = c;
                    e.b   = p[3-b];
                    e.pe  = (b == 3);
                    e.det = (b == 3) && (p == PAT_1011);
                    line_q.push_back(e);
                end
                c++;
            end
            if (i < r - 1) begin
                for (int z = 0; z < g; z++) begin
                    if (rst_at == 0 || c < k + rst_at) begin
                        e.c   = c;
                        e.b   = 1'b0;
                        e.pe  = 1'b0;
                        e.det = 1'b0;
                        line_q.push_back(e);
                    end
                    c++;
                end
            end
        end
        if (rst_at == 0) done_q.push_back(c);

        ncyc = (rst_at > 0) ? rst_at + 3 : total + 4;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            if (glitch_at > 0 && cyc + 1 == k + glitch_at) begin
                start   = 1'b1;
                pattern = 4'b0110;
                reps    = 8'd5;
                gap     = 4'd3;
            end
            if (rst_at > 0 && cyc + 1 == k + rst_at) rst = 1'b1;
            if (rst_at > 0 && cyc >= k + rst_at) begin
                chk("rst_ser_out", ser_out, 0);
                chk("rst_ser_valid", ser_valid, 0);
                chk("rst_pat_end", pat_end, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        if (rst_at == 0) begin
            chk("valid_count", n_valid - bv, total);
            chk("pat_end_count", n_pend - bp, r);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ser_out", ser_out, 0);
        chk("reset_ser_valid", ser_valid, 0);
        chk("reset_pat_end", pat_end, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;

        run(PAT_1011, 1, 0, 0, 0);      // single pattern
        run(PAT_1011, 3, 2, 0, 0);      // gapped repetitions
        run(PAT_1011, 2, 0, 0, 0);      // back-to-back, overlap check
        run(PAT_1011, 0, 5, 0, 0);      // reps=0: done only
        run(PAT_1011, 1, 0, 2, 0);      // stray start mid-transfer
        run(4'b0110, 2, 1, 0, 0);       // non-detecting pattern
        run(PAT_1011, 2, 1, 2, 3);      // stray start then reset
        run(PAT_1011, 1, 0, 0, 0);      // accepted after reset
        run(PAT_1011, 255, 15, 0, 0);   // maximum counts

        repeat (3) @(negedge clk);
        chk("line_queue_drained", line_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: accepts a PAT_W-bit pattern, a repetition count and an inter-pattern gap length, then drives the pattern MSB-first onto a one-bit serial line. Each repetition is separated by a run of zero bits. It is the stimulus and transmit end of the serial pattern-detection path: it produces the line that a downstream pattern detector (e.g. the overlapping 1011 detector) consumes. It also flags exactly where each pattern ends, so the detector response can be checked cycle-accurately.

## Interface
- PAT_W, 4, pattern width in bits (≥2)
- CNT_W, 8, width of repetition count
- GAP_W, 4, width of gap length
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- pattern  in  PAT_W  pattern to send, MSB first; captured on accepted start
- reps  in  CNT_W  number of repetitions; captured on accepted start
- gap  in  GAP_W  zero bits inserted between repetitions; captured on accepted start
- ser_out  out  1  serial line bit
- ser_valid  out  1  high while ser_out carries a line bit (pattern or gap)
- pat_end  out  1  high during the last bit of each pattern repetition
- busy  out  1  high while a transfer is in SEND or GAP
- done  out  1  one-cycle pulse after the final line bit

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 with reps≠0: load the shift register with pattern, rep_cnt=reps, gap_len=gap, bit_cnt=PAT_W-1; go to SEND.
  - start=1 with reps=0: go to DONE, with no line bits.
  - start=0: stay in IDLE.
- SEND:
  - ser_out = shift MSB; ser_valid=1; shift left each cycle; bit_cnt decrements.
  - At bit_cnt=0: pat_end=1 and rep_cnt decrements.
  - If this is the last repetition, go to DONE.
  - Else if gap_len=0, reload the shift register from the captured pattern, reset bit_cnt and stay in SEND (back-to-back patterns).
  - Else go to GAP.
- GAP:
  - ser_out=0, ser_valid=1, for exactly gap_len cycles.
  - After the last gap cycle, reload the pattern and go to SEND.
- DONE: done=1 for one cycle, then go to IDLE.
- start is ignored in SEND, GAP and DONE; pattern, reps and gap may change freely after capture.
- No gap is emitted after the final repetition.
- Total line cycles per transfer = reps·PAT_W + (reps−1)·gap. Counters are sized to hold reps=2^CNT_W−1 and gap=2^GAP_W−1 without overflow.
- Outside SEND/GAP: ser_out=0, ser_valid=0, pat_end=0, busy=0.

## Timing
- All outputs are registered.
- Reset value: state IDLE; ser_out=0, ser_valid=0, pat_end=0, busy=0, done=0.
- Latency: for start accepted at edge k, the first bit (pattern MSB) is on ser_out from edge k+1, with busy=1.
- Each line bit lasts exactly one cycle; the line has no idle bubbles between the pattern and gap phases.
- Final line bit at edge n: done=1 and busy=0 from edge n+1; IDLE from edge n+2, when a new start can be accepted.
- reps=0: done=1 at edge k+1; busy and ser_valid never assert.
- Reset mid-transfer: all outputs are 0 on the next edge, state is IDLE, and no done pulse is produced.
- rst has priority over start.

## Structure
- Shared package seq_pkg:
  - State enum: IDLE, SEND, GAP, DONE.
  - Constant PAT_1011 = 4'b1011.
  - Default width constants.
- Single module. No sub-module: the shift register and three down-counters (bit, gap, rep) live in one FSM.
- Bench-only loopback: the bench drives ser_out into an overlapping-1011 detector model.

## Test plan
- Single pattern: pattern=1011, reps=1, gap=0, start at edge 0.
  - ser_out=1,0,1,1 at edges 1–4, with ser_valid high for all four; pat_end at edge 4.
  - done at edge 5; busy high at edges 1–4.
- Gapped repetitions: pattern=1011, reps=3, gap=2.
  - Line is 1011 00 1011 00 1011 over 16 valid cycles.
  - pat_end at edges 4, 10, 16; done at 17.
- Back-to-back (overlap check): pattern=1011, reps=2, gap=0.
  - Line is 10111011; pat_end at edges 4 and 8.
  - The loopback detector model fires after bits 4 and 8 only.
- reps=0: done at edge 1; ser_valid, busy and pat_end stay 0 throughout.
- Ignored start and mid-transfer reset:
  - Pulse start with pattern=0110 at edge 2 of a 1011 transfer: it is ignored and the line remains 1011.
  - Assert rst at edge 3: all outputs are 0 from edge 4, no done pulse, and a new start at edge 6 is accepted normally.
- Maximum counts: pattern=1011, reps=255, gap=15.
  - Exactly 4830 valid cycles, 255 pat_end pulses and one done pulse.
